// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for a single Avalon-style memory port (M0 = ifetch, M1 = load/store).
// Grant is held for a whole transfer; a watchdog aborts transfers stalled by a hung slave.

module mem_bus_arbiter_port #(
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic        granted,
   input  logic        abort,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] mem_readdata,
   input  logic        mem_waitrequest,
   output logic        req,
   output logic [31:0] readdata,
   output logic        waitrequest
);
   assign req = rd | wr;

   // A requester that does not own the bus is always stalled and sees zero data.
   always_comb begin
      readdata    = '0;
      waitrequest = 1'b1;
      if (granted) begin
         if (abort) begin
            readdata    = ERR_DATA;
            waitrequest = 1'b0;
         end else begin
            readdata    = mem_readdata;
            waitrequest = mem_waitrequest;
         end
      end
   end
endmodule

module mem_bus_arbiter #(
   parameter int          PRIORITY_MODE  = 0,
   parameter int          TIMEOUT_CYCLES = 16,
   parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] m0_address,
   input  logic        m0_read,
   input  logic        m0_write,
   input  logic [31:0] m0_writedata,
   input  logic [3:0]  m0_byteenable,
   output logic [31:0] m0_readdata,
   output logic        m0_waitrequest,
   input  logic [31:0] m1_address,
   input  logic        m1_read,
   input  logic        m1_write,
   input  logic [31:0] m1_writedata,
   input  logic [3:0]  m1_byteenable,
   output logic [31:0] m1_readdata,
   output logic        m1_waitrequest,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic [31:0] readdata,
   input  logic        waitrequest,
   output logic        timeout_err
);
   localparam int             CW      = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]  TMAX    = CW'(TIMEOUT_CYCLES);
   localparam bit             WDOG_EN = (TIMEOUT_CYCLES != 0);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state, state_nx;
   logic            owner, owner_nx;
   logic            last_owner, last_nx;
   logic [CW-1:0]   wait_cnt, cnt_nx;
   logic            err_nx;
   logic            abort;

   logic [1:0][31:0] m_addr, m_wdata, port_rdata;
   logic [1:0][3:0]  m_be;
   logic [1:0]       m_rd, m_wr, req, granted, port_wait;

   assign m_addr  = {m1_address, m0_address};
   assign m_wdata = {m1_writedata, m0_writedata};
   assign m_be    = {m1_byteenable, m0_byteenable};
   assign m_rd    = {m1_read, m0_read};
   assign m_wr    = {m1_write, m0_write};

   assign granted[0] = (state == BUSY) && !owner;
   assign granted[1] = (state == BUSY) && owner;

   genvar n;
   generate
      for (n = 0; n < 2; n++) begin : g_port
         mem_bus_arbiter_port #(.ERR_DATA(ERR_DATA)) u_port (
            .granted         (granted[n]),
            .abort           (abort),
            .rd              (m_rd[n]),
            .wr              (m_wr[n]),
            .mem_readdata    (readdata),
            .mem_waitrequest (waitrequest),
            .req             (req[n]),
            .readdata        (port_rdata[n]),
            .waitrequest     (port_wait[n])
         );
      end
   endgenerate

   assign m0_readdata    = port_rdata[0];
   assign m1_readdata    = port_rdata[1];
   assign m0_waitrequest = port_wait[0];
   assign m1_waitrequest = port_wait[1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         owner       <= 1'b0;
         last_owner  <= 1'b1;
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nx;
         owner       <= owner_nx;
         last_owner  <= last_nx;
         wait_cnt    <= cnt_nx;
         timeout_err <= err_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      owner_nx   = owner;
      last_nx    = last_owner;
      cnt_nx     = wait_cnt;
      err_nx     = timeout_err;
      abort      = 1'b0;
      address    = '0;
      read       = 1'b0;
      write      = 1'b0;
      writedata  = '0;
      byteenable = '0;
      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (req[0] || req[1]) begin
               state_nx = BUSY;
               if (req[0] && req[1])
                  owner_nx = (PRIORITY_MODE != 0) ? 1'b0 : ~last_owner;
               else
                  owner_nx = req[1];
            end
         end
         BUSY: begin
            address    = m_addr[owner];
            writedata  = m_wdata[owner];
            byteenable = m_be[owner];
            write      = m_wr[owner];
            read       = m_rd[owner] & ~m_wr[owner];
            // The watchdog wins over everything else so a stuck slave always gets released.
            if (WDOG_EN && (wait_cnt == TMAX)) begin
               abort    = 1'b1;
               read     = 1'b0;
               write    = 1'b0;
               err_nx   = 1'b1;
               state_nx = IDLE;
               last_nx  = owner;
               cnt_nx   = '0;
            end else if (!req[owner]) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else if (!waitrequest) begin
               state_nx = IDLE;
               last_nx  = owner;
               cnt_nx   = '0;
            end else if (wait_cnt != TMAX) begin
               cnt_nx = wait_cnt + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vector table, hand sequences for reset/priority,
// then random traffic checked against a transaction-level model.
module tb_mem_bus_arbiter;
   localparam int          TO  = 4;
   localparam logic [31:0] ERR = 32'hDEADBEEF;
   localparam logic [31:0] A0 = 32'hBFC00000, A1 = 32'hBFC00010;
   localparam logic [31:0] D0 = 32'h0, D1 = 32'hCAFEF00D, RD = 32'h12345678;
   localparam logic [3:0]  BE0 = 4'hF, BE1 = 4'b0011;

   logic clk = 1'b0, reset = 1'b0;
   logic [31:0] m0_address, m0_writedata, m1_address, m1_writedata, readdata;
   logic        m0_read, m0_write, m1_read, m1_write, waitrequest;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic [31:0] m0_readdata, m1_readdata, address, writedata;
   logic        m0_waitrequest, m1_waitrequest, read, write, timeout_err;
   logic [3:0]  byteenable;
   logic [31:0] p_m0_readdata, p_m1_readdata, p_address, p_writedata;
   logic        p_m0_waitrequest, p_m1_waitrequest, p_read, p_write, p_timeout_err;
   logic [3:0]  p_byteenable;

   int tests = 0, fails = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)) dut (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
      .m0_byteenable(m0_byteenable), .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
      .m1_byteenable(m1_byteenable), .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
      .address(address), .read(read), .write(write), .writedata(writedata), .byteenable(byteenable),
      .readdata(readdata), .waitrequest(waitrequest), .timeout_err(timeout_err));

   mem_bus_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)) dut_p (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
      .m0_byteenable(m0_byteenable), .m0_readdata(p_m0_readdata), .m0_waitrequest(p_m0_waitrequest),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
      .m1_byteenable(m1_byteenable), .m1_readdata(p_m1_readdata), .m1_waitrequest(p_m1_waitrequest),
      .address(p_address), .read(p_read), .write(p_write), .writedata(p_writedata),
      .byteenable(p_byteenable), .readdata(readdata), .waitrequest(waitrequest),
      .timeout_err(p_timeout_err));

   typedef struct {
      logic m0r, m0w, m1r, m1w, wr;
      logic [31:0] e_addr; logic e_rd, e_wr; logic [31:0] e_wdata; logic [3:0] e_be;
      logic e_m0wait, e_m1wait; logic [31:0] e_m0rd, e_m1rd; logic e_err;
   } vec_t;
   vec_t tbl[$];

   function automatic logic [136:0] pk(logic [31:0] a, logic r, logic w, logic [31:0] wd,
                                       logic [3:0] be, logic w0, logic w1, logic [31:0] r0,
                                       logic [31:0] r1, logic e);
      return {a, r, w, wd, be, w0, w1, r0, r1, e};
   endfunction

   function automatic logic [136:0] dut_out();
      return pk(address, read, write, writedata, byteenable, m0_waitrequest, m1_waitrequest,
                m0_readdata, m1_readdata, timeout_err);
   endfunction

   function automatic logic [136:0] p_out();
      return pk(p_address, p_read, p_write, p_writedata, p_byteenable, p_m0_waitrequest,
                p_m1_waitrequest, p_m0_readdata, p_m1_readdata, p_timeout_err);
   endfunction

   task automatic chk(string nm, logic [136:0] got, logic [136:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Idle-cycle vector: nothing reaches memory, both requesters stalled.
   function automatic vec_t vi(logic m0r, m0w, m1r, m1w, wr, err);
      vec_t v;
      v.m0r = m0r; v.m0w = m0w; v.m1r = m1r; v.m1w = m1w; v.wr = wr;
      v.e_addr = '0; v.e_rd = 0; v.e_wr = 0; v.e_wdata = '0; v.e_be = '0;
      v.e_m0wait = 1; v.e_m1wait = 1; v.e_m0rd = '0; v.e_m1rd = '0; v.e_err = err;
      return v;
   endfunction

   // Busy-cycle vector for owner o.
   function automatic vec_t vb(logic m0r, m0w, m1r, m1w, wr, int o, logic erd, ewr, ow,
                               logic [31:0] ord, logic err);
      vec_t v;
      v = vi(m0r, m0w, m1r, m1w, wr, err);
      v.e_addr = o ? A1 : A0; v.e_wdata = o ? D1 : D0; v.e_be = o ? BE1 : BE0;
      v.e_rd = erd; v.e_wr = ewr;
      if (o == 0) begin v.e_m0wait = ow; v.e_m0rd = ord; end
      else        begin v.e_m1wait = ow; v.e_m1rd = ord; end
      return v;
   endfunction

   task automatic drive_fixed(logic m0r, m0w, m1r, m1w, wr);
      m0_address = A0; m0_writedata = D0; m0_byteenable = BE0;
      m1_address = A1; m1_writedata = D1; m1_byteenable = BE1;
      readdata = RD;
      m0_read = m0r; m0_write = m0w; m1_read = m1r; m1_write = m1w; waitrequest = wr;
   endtask

   // Random-phase stimulus state and reference model.
   bit act[2], rdq[2], wrq[2], done[2];
   logic [31:0] radr[2], rwd[2];
   logic [3:0]  rbe[2];
   int cur, last, stall, stuck;
   bit merr;

   initial begin
      vec_t v;
      logic [136:0] e;
      drive_fixed(1, 0, 1, 0, 0);

      // Reset held with both requesting: nothing may leave either arbiter.
      @(negedge clk); #1;
      chk("reset_out", dut_out(), pk('0, 0, 0, '0, '0, 1, 1, '0, '0, 0));
      chk("reset_out_p", p_out(), pk('0, 0, 0, '0, '0, 1, 1, '0, '0, 0));
      drive_fixed(0, 0, 0, 0, 0);
      reset = 1'b1;

      // Round robin from reset: M0, M1, M0, M1.
      repeat (2) begin
         tbl.push_back(vi(1,0,1,0,0,0)); tbl.push_back(vb(1,0,1,0,0,0,1,0,0,RD,0));
         tbl.push_back(vi(1,0,1,0,0,0)); tbl.push_back(vb(1,0,1,0,0,1,1,0,0,RD,0));
      end
      // Single M0 read, zero wait.
      tbl.push_back(vi(1,0,0,0,0,0)); tbl.push_back(vb(1,0,0,0,0,0,1,0,0,RD,0));
      tbl.push_back(vi(0,0,0,0,0,0));
      // M1 write with 3 wait cycles while M0 waits its turn.
      tbl.push_back(vi(0,0,0,1,1,0));
      repeat (3) tbl.push_back(vb(1,0,0,1,1,1,0,1,1,RD,0));
      tbl.push_back(vb(1,0,0,1,0,1,0,1,0,RD,0));
      tbl.push_back(vi(1,0,0,0,0,0)); tbl.push_back(vb(1,0,0,0,0,0,1,0,0,RD,0));
      tbl.push_back(vi(0,0,0,0,0,0));
      // read and write together: write wins.
      tbl.push_back(vi(1,1,0,0,0,0)); tbl.push_back(vb(1,1,0,0,0,0,0,1,0,RD,0));
      // Watchdog: stuck slave, abort in 5th busy cycle, sticky error.
      tbl.push_back(vi(1,0,0,0,1,0));
      repeat (4) tbl.push_back(vb(1,0,0,0,1,0,1,0,1,RD,0));
      tbl.push_back(vb(1,0,0,0,1,0,0,0,0,ERR,0));
      tbl.push_back(vi(0,0,0,0,1,1)); tbl.push_back(vi(0,0,1,0,0,1));
      tbl.push_back(vb(0,0,1,0,0,1,1,0,0,RD,1));

      for (int i = 0; i < tbl.size(); i++) begin
         v = tbl[i];
         @(negedge clk);
         drive_fixed(v.m0r, v.m0w, v.m1r, v.m1w, v.wr);
         #1;
         e = pk(v.e_addr, v.e_rd, v.e_wr, v.e_wdata, v.e_be, v.e_m0wait, v.e_m1wait,
                v.e_m0rd, v.e_m1rd, v.e_err);
         chk($sformatf("vec%0d", i), dut_out(), e);
      end

      // Reset mid-transfer after M0 last owned the bus; next contention must still go to M0.
      @(negedge clk); drive_fixed(1, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk); drive_fixed(1, 0, 0, 0, 1);
      @(negedge clk); #1;
      chk("busy_before_reset", {135'b0, read, m0_waitrequest}, {135'b0, 2'b11});
      #1 reset = 1'b0; #1;
      chk("async_reset", dut_out(), pk('0, 0, 0, '0, '0, 1, 1, '0, '0, 0));
      @(negedge clk); reset = 1'b1; drive_fixed(1, 0, 1, 0, 0); #1;
      chk("post_reset_idle", dut_out(), pk('0, 0, 0, '0, '0, 1, 1, '0, '0, 0));
      @(negedge clk); #1;
      chk("post_reset_m0", dut_out(), pk(A0, 1, 0, D0, BE0, 0, 1, RD, '0, 0));

      // Fixed priority: M1 starves while M0 keeps requesting.
      @(negedge clk); reset = 1'b0; drive_fixed(1, 0, 1, 0, 0); #1 reset = 1'b1;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk); #1;
         chk($sformatf("prio_starve%0d", k), {135'b0, p_m0_waitrequest, p_m1_waitrequest},
             {135'b0, (k % 2) != 0, 1'b1});
      end
      @(negedge clk); drive_fixed(0, 0, 1, 0, 0); #1;
      chk("prio_idle", {135'b0, p_m0_waitrequest, p_m1_waitrequest}, {135'b0, 2'b11});
      @(negedge clk); #1;
      chk("prio_m1_grant", p_out(), pk(A1, 1, 0, D1, BE1, 1, 0, '0, RD, 0));

      // Random traffic against the transaction-level model.
      @(negedge clk); reset = 1'b0; drive_fixed(0, 0, 0, 0, 0); #1 reset = 1'b1;
      cur = -1; last = 1; stall = 0; merr = 0; stuck = 0;
      for (int n = 0; n < 2; n++) begin act[n] = 0; done[n] = 0; end
      for (int c = 0; c < 1500; c++) begin
         logic [31:0] ea, ewd, er0, er1;
         logic [3:0] ebe;
         logic erd, ewr, ew0, ew1;
         bit ab;
         @(negedge clk);
         for (int n = 0; n < 2; n++) begin
            if (done[n]) act[n] = 0;
            done[n] = 0;
            if (!act[n] && $urandom_range(0, 2) != 0) begin
               int kind;
               kind = $urandom_range(0, 3);
               act[n] = 1; rdq[n] = (kind != 2); wrq[n] = (kind >= 2);
               radr[n] = $urandom; rwd[n] = $urandom; rbe[n] = 4'($urandom);
            end
         end
         if (stuck > 0) begin waitrequest = 1; stuck--; end
         else if ($urandom_range(0, 19) == 0) begin stuck = $urandom_range(3, 8); waitrequest = 1; end
         else waitrequest = ($urandom_range(0, 2) == 0);
         readdata = $urandom;
         m0_address = radr[0]; m0_writedata = rwd[0]; m0_byteenable = rbe[0];
         m1_address = radr[1]; m1_writedata = rwd[1]; m1_byteenable = rbe[1];
         m0_read = act[0] & rdq[0]; m0_write = act[0] & wrq[0];
         m1_read = act[1] & rdq[1]; m1_write = act[1] & wrq[1];
         #1;
         ea = '0; ewd = '0; ebe = '0; erd = 0; ewr = 0; ew0 = 1; ew1 = 1; er0 = '0; er1 = '0;
         if (cur < 0) begin
            if (act[0] && act[1]) cur = 1 - last;
            else if (act[0]) cur = 0;
            else if (act[1]) cur = 1;
            stall = 0;
            e = pk(ea, erd, ewr, ewd, ebe, ew0, ew1, er0, er1, merr);
         end else begin
            ab = (stall == TO);
            ea = radr[cur]; ewd = rwd[cur]; ebe = rbe[cur];
            ewr = act[cur] && wrq[cur] && !ab;
            erd = act[cur] && rdq[cur] && !wrq[cur] && !ab;
            if (cur == 0) begin ew0 = ab ? 1'b0 : waitrequest; er0 = ab ? ERR : readdata; end
            else          begin ew1 = ab ? 1'b0 : waitrequest; er1 = ab ? ERR : readdata; end
            e = pk(ea, erd, ewr, ewd, ebe, ew0, ew1, er0, er1, merr);
            if (ab) begin
               merr = 1; last = cur; done[cur] = 1; cur = -1; stall = 0;
            end else if (!waitrequest) begin
               last = cur; done[cur] = 1; cur = -1; stall = 0;
            end else if (stall < TO) stall++;
         end
         chk($sformatf("rand%0d", c), dut_out(), e);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
